// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, reads instruction words over
// the iREN/ihit handshake, holds each word for decode behind a valid/ready
// handshake, applies downstream redirects and stops for good after HALT.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_npc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e      state_q,     state_d;
  logic [31:0] fetch_pc_q,  fetch_pc_d;
  logic [31:0] instr_q,     instr_d;
  logic [31:0] instr_pc_q,  instr_pc_d;
  logic [31:0] instr_npc_q, instr_npc_d;
  logic        halted_q,    halted_d;
  logic [31:0] retired_q,   retired_d;

  logic        accept;
  logic [31:0] redirect_tgt;
  logic [31:0] fetch_pc_inc;

  // Redirect targets are word aligned; the low two bits are discarded.
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  // Wraps modulo 2^32 naturally through the 32-bit result width.
  assign fetch_pc_inc = fetch_pc_q + 32'd4;
  assign accept       = (state_q == HOLD) && instr_ready;

  // Next-state and register updates; halt beats redirect, redirect beats ihit/accept.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    instr_npc_d = instr_npc_q;
    halted_d    = halted_q;
    retired_d   = retired_q;

    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          // Any word returning this cycle belongs to the squashed path.
          fetch_pc_d = redirect_tgt;
        end else if (ihit) begin
          instr_d     = imemload;
          instr_pc_d  = fetch_pc_q;
          instr_npc_d = fetch_pc_inc;
          fetch_pc_d  = fetch_pc_inc;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          retired_d = retired_q + 32'd1;
        end
        if (accept && halt) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else if (redirect_valid) begin
          fetch_pc_d = redirect_tgt;
          state_d    = FETCH;
        end else if (accept) begin
          state_d = FETCH;
        end
      end
      HALTED: begin
        // Terminal until reset; all inputs ignored.
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      state_q     <= FETCH;
      fetch_pc_q  <= PC_INIT;
      instr_q     <= 32'd0;
      instr_pc_q  <= 32'd0;
      instr_npc_q <= 32'd4;
      halted_q    <= 1'b0;
      retired_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      instr_npc_q <= instr_npc_d;
      halted_q    <= halted_d;
      retired_q   <= retired_d;
    end
  end

  assign imemREN     = (state_q == FETCH);
  assign imemaddr    = fetch_pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_npc   = instr_npc_q;
  assign halted      = halted_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: straight-line fetch, wait states,
// backpressure, redirects, halt, reset mid-hold and PC wrap.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic [31:0] instr, instr_pc, instr_npc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic [31:0] retired;

  // Second instance for the PC wrap case.
  logic        w_rst, w_ihit, w_ready;
  logic [31:0] w_load;
  logic        w_redirect_valid, w_halt;
  logic [31:0] w_redirect_pc;
  logic        w_ren, w_valid, w_halted;
  logic [31:0] w_addr, w_instr, w_instr_pc, w_instr_npc, w_retired;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload),
    .instr(instr), .instr_pc(instr_pc), .instr_npc(instr_npc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted), .retired(retired)
  );

  fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) u_wrap (
    .CLK(CLK), .RST(w_rst),
    .imemREN(w_ren), .imemaddr(w_addr),
    .ihit(w_ihit), .imemload(w_load),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_npc(w_instr_npc),
    .instr_valid(w_valid), .instr_ready(w_ready),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .halt(w_halt), .halted(w_halted), .retired(w_retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; imemload = 32'd0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
    w_rst = 1'b1; w_ihit = 1'b0; w_ready = 1'b0; w_load = 32'd0;
    w_redirect_valid = 1'b0; w_redirect_pc = 32'd0; w_halt = 1'b0;
    @(negedge CLK);
    tick;

    // Reset state
    check("rst_ren",     {31'd0, imemREN},     32'd1);
    check("rst_addr",    imemaddr,             32'd0);
    check("rst_valid",   {31'd0, instr_valid}, 32'd0);
    check("rst_instr",   instr,                32'd0);
    check("rst_ipc",     instr_pc,             32'd0);
    check("rst_halted",  {31'd0, halted},      32'd0);
    check("rst_retired", retired,              32'd0);

    // Straight-line fetch: request, hold, request ...
    RST = 1'b0; ihit = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("sl_ren",   {31'd0, imemREN},     32'd1);
      check("sl_addr",  imemaddr,             32'(4 * k));
      check("sl_valid", {31'd0, instr_valid}, 32'd0);
      imemload = 32'hA000_0000 | 32'(4 * k);
      tick;
      check("sl_hvalid", {31'd0, instr_valid}, 32'd1);
      check("sl_hren",   {31'd0, imemREN},     32'd0);
      check("sl_instr",  instr,                32'hA000_0000 | 32'(4 * k));
      check("sl_ipc",    instr_pc,             32'(4 * k));
      check("sl_npc",    instr_npc,            32'(4 * k + 4));
      tick;
    end
    check("sl_retired", retired, 32'd4);

    // Wait states at 0x10: ihit arrives on the fourth request cycle
    ihit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("ws_ren",   {31'd0, imemREN},     32'd1);
      check("ws_addr",  imemaddr,             32'h10);
      check("ws_valid", {31'd0, instr_valid}, 32'd0);
      if (k == 3) begin
        ihit = 1'b1;
        imemload = 32'h1111_0010;
      end
      tick;
    end
    ihit = 1'b0;
    check("ws_instr", instr,    32'h1111_0010);
    check("ws_ipc",   instr_pc, 32'h10);
    tick;
    check("ws_next",    imemaddr, 32'h14);
    check("ws_retired", retired,  32'd5);

    // Backpressure while holding 0x2108000A at 0x40
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick;
    redirect_valid = 1'b0;
    check("bp_addr", imemaddr, 32'h40);
    ihit = 1'b1; imemload = 32'h2108_000A; instr_ready = 1'b0;
    tick;
    ihit = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_instr",   instr,                32'h2108_000A);
      check("bp_ipc",     instr_pc,             32'h40);
      check("bp_ren",     {31'd0, imemREN},     32'd0);
      check("bp_valid",   {31'd0, instr_valid}, 32'd1);
      check("bp_retired", retired,              32'd5);
      tick;
    end
    instr_ready = 1'b1;
    tick;
    check("bp_next",    imemaddr, 32'h44);
    check("bp_retired2", retired, 32'd6);

    // Redirect in FETCH coincident with ihit: word dropped
    ihit = 1'b1; imemload = 32'hDEAD_BEEF; redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick;
    redirect_valid = 1'b0;
    check("rf_addr",  imemaddr,             32'h80);
    check("rf_ren",   {31'd0, imemREN},     32'd1);
    check("rf_valid", {31'd0, instr_valid}, 32'd0);

    // Accept plus redirect to 0x203 at instr_pc 0x80
    imemload = 32'h0800_0080; instr_ready = 1'b0;
    tick;
    ihit = 1'b0;
    check("ar_ipc", instr_pc, 32'h80);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick;
    redirect_valid = 1'b0;
    check("ar_addr",    imemaddr,             32'h200);
    check("ar_valid",   {31'd0, instr_valid}, 32'd0);
    check("ar_retired", retired,              32'd7);

    // Redirect in FETCH at 0x200 with ihit, target 0x200
    ihit = 1'b1; imemload = 32'hBAD0_0200; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick;
    redirect_valid = 1'b0;
    check("rf2_addr",  imemaddr,             32'h200);
    check("rf2_valid", {31'd0, instr_valid}, 32'd0);

    // Redirect in HOLD without accept: held word discarded
    imemload = 32'h0000_0200; instr_ready = 1'b0;
    tick;
    ihit = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick;
    redirect_valid = 1'b0;
    check("rh_addr",    imemaddr,             32'h300);
    check("rh_valid",   {31'd0, instr_valid}, 32'd0);
    check("rh_retired", retired,              32'd7);

    // Halt: ignored without ready, then wins over a coincident redirect
    ihit = 1'b1; imemload = 32'hFC00_0000;
    tick;
    ihit = 1'b0; halt = 1'b1;
    tick;
    check("h_noacc_valid",  {31'd0, instr_valid}, 32'd1);
    check("h_noacc_halted", {31'd0, halted},      32'd0);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
    tick;
    check("h_halted",  {31'd0, halted},      32'd1);
    check("h_ren",     {31'd0, imemREN},     32'd0);
    check("h_valid",   {31'd0, instr_valid}, 32'd0);
    check("h_retired", retired,              32'd8);
    halt = 1'b0; ihit = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("hs_halted",  {31'd0, halted},  32'd1);
      check("hs_ren",     {31'd0, imemREN}, 32'd0);
      check("hs_addr",    imemaddr,         32'h304);
      check("hs_retired", retired,          32'd8);
    end
    redirect_valid = 1'b0; ihit = 1'b0;

    // Reset out of HALTED, retire one, then reset in HOLD
    RST = 1'b1;
    tick;
    RST = 1'b0;
    check("rr_halted", {31'd0, halted}, 32'd0);
    check("rr_addr",   imemaddr,        32'd0);
    ihit = 1'b1; imemload = 32'h1234_5678; instr_ready = 1'b1;
    tick;
    tick;
    check("rr_retired", retired, 32'd1);
    instr_ready = 1'b0;
    tick;
    check("rh_hold", {31'd0, instr_valid}, 32'd1);
    RST = 1'b1;
    tick;
    RST = 1'b0; ihit = 1'b0;
    check("rm_valid",   {31'd0, instr_valid}, 32'd0);
    check("rm_addr",    imemaddr,             32'd0);
    check("rm_retired", retired,              32'd0);
    check("rm_ren",     {31'd0, imemREN},     32'd1);

    // PC wrap on the second instance
    w_rst = 1'b0;
    tick;
    check("w_addr0", w_addr, 32'hFFFF_FFFC);
    w_ihit = 1'b1; w_load = 32'h0000_0001;
    tick;
    w_ihit = 1'b0;
    check("w_ipc", w_instr_pc,  32'hFFFF_FFFC);
    check("w_npc", w_instr_npc, 32'd0);
    w_ready = 1'b1;
    tick;
    check("w_addr1", w_addr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
